prog_sequencer: RTL and testbench

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer.sv | 171 +++++++++++++++++
 tb/tb_prog_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Runs up to three controller-core programs in ascending index order.
// Each program gets one start pulse and a RUN-cycle count (capped at TIMEOUT).
module prog_sequencer #(
  parameter int PC_W    = 10,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096,
  parameter int ADDR0   = 0,
  parameter int ADDR1   = 128,
  parameter int ADDR2   = 256
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [2:0]       prog_mask,
  input  logic             abort,
  input  logic             core_done,
  output logic             core_start,
  output logic [PC_W-1:0]  core_start_addr,
  output logic             busy,
  output logic             result_valid,
  output logic [1:0]       result_prog,
  output logic [CNT_W-1:0] result_cycles,
  output logic             result_timeout,
  output logic             all_done,
  output logic [2:0]       debug_state
);

  // Handshake: go is accepted only in IDLE; core_start is a one-cycle pulse
  // and core_done is a level that only counts while in RUN.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_RECORD = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);

  state_t            state_q;
  logic [2:0]        mask_q;
  logic [1:0]        prog_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              core_start_q;
  logic [PC_W-1:0]   start_addr_q;
  logic              busy_q;
  logic              result_valid_q;
  logic [1:0]        result_prog_q;
  logic [CNT_W-1:0]  result_cycles_q;
  logic              result_timeout_q;
  logic              all_done_q;

  logic [2:0]        rem_mask_d;
  logic [1:0]        first_prog_d;
  logic [1:0]        next_prog_d;

  function automatic logic [1:0] lowest(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  function automatic logic [PC_W-1:0] addr_of(input logic [1:0] p);
    case (p)
      2'd0:    return PC_W'(ADDR0);
      2'd1:    return PC_W'(ADDR1);
      default: return PC_W'(ADDR2);
    endcase
  endfunction

  assign rem_mask_d   = mask_q & ~(3'b001 << prog_q);
  assign first_prog_d = lowest(prog_mask);
  assign next_prog_d  = lowest(rem_mask_d);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      mask_q           <= '0;
      prog_q           <= '0;
      cnt_q            <= '0;
      core_start_q     <= 1'b0;
      start_addr_q     <= '0;
      busy_q           <= 1'b0;
      result_valid_q   <= 1'b0;
      result_prog_q    <= '0;
      result_cycles_q  <= '0;
      result_timeout_q <= 1'b0;
      all_done_q       <= 1'b0;
    end else begin
      core_start_q   <= 1'b0;
      result_valid_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (go) begin
              all_done_q <= 1'b0;
              busy_q     <= 1'b1;
              if (prog_mask != 3'b000) begin
                mask_q       <= prog_mask;
                prog_q       <= first_prog_d;
                core_start_q <= 1'b1;
                start_addr_q <= addr_of(first_prog_d);
                state_q      <= S_LAUNCH;
              end else begin
                state_q <= S_FINISH;
              end
            end
          end
          // core_done is deliberately not looked at here: it may still be
          // asserted from the program that just finished.
          S_LAUNCH: begin
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
          S_RUN: begin
            if (core_done) begin
              result_valid_q   <= 1'b1;
              result_prog_q    <= prog_q;
              result_cycles_q  <= cnt_q + 1'b1;
              result_timeout_q <= 1'b0;
              state_q          <= S_RECORD;
            end else if (cnt_q == LAST_CNT) begin
              result_valid_q   <= 1'b1;
              result_prog_q    <= prog_q;
              result_cycles_q  <= TO_CNT;
              result_timeout_q <= 1'b1;
              state_q          <= S_RECORD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_RECORD: begin
            mask_q <= rem_mask_d;
            if (rem_mask_d != 3'b000) begin
              prog_q       <= next_prog_d;
              core_start_q <= 1'b1;
              start_addr_q <= addr_of(next_prog_d);
              state_q      <= S_LAUNCH;
            end else begin
              state_q <= S_FINISH;
            end
          end
          S_FINISH: begin
            all_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign core_start      = core_start_q;
  assign core_start_addr = start_addr_q;
  assign busy            = busy_q;
  assign result_valid    = result_valid_q;
  assign result_prog     = result_prog_q;
  assign result_cycles   = result_cycles_q;
  assign result_timeout  = result_timeout_q;
  assign all_done        = all_done_q;
  assign debug_state     = state_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a timeline model predicts every start pulse,
// result and busy/all_done level from the program plan and injected aborts/resets.
module tb_prog_sequencer;

  localparam int TO   = 60;
  localparam int MAXC = 16384;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go;
  logic [2:0]  prog_mask;
  logic        abort;
  logic        core_done = 1'b0;
  logic        core_start;
  logic [9:0]  core_start_addr;
  logic        busy;
  logic        result_valid;
  logic [1:0]  result_prog;
  logic [15:0] result_cycles;
  logic        result_timeout;
  logic        all_done;
  logic [2:0]  debug_state;

  prog_sequencer #(
    .PC_W(10), .CNT_W(16), .TIMEOUT(TO), .ADDR0(0), .ADDR1(128), .ADDR2(256)
  ) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .prog_mask(prog_mask), .abort(abort),
    .core_done(core_done), .core_start(core_start), .core_start_addr(core_start_addr),
    .busy(busy), .result_valid(result_valid), .result_prog(result_prog),
    .result_cycles(result_cycles), .result_timeout(result_timeout),
    .all_done(all_done), .debug_state(debug_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  bit rst_hit = 1'b0;
  always @(posedge clk) begin
    cyc     = cyc + 1;
    rst_hit = !reset_n;
  end

  // ---------------- model state ----------------
  int          addr_tab[3] = '{0, 128, 256};
  bit          busy_arr[MAXC];
  bit          ad_arr[MAXC];
  logic [41:0] start_q[$];   // {cycle, addr}
  logic [50:0] exp_q[$];     // {cycle, prog, cycles, timeout}
  int          d_q[$];       // done delay per launched program
  logic [18:0] last_res = '0;
  int          k = 0;
  int          d_cur = 1 << 30;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- scoreboard + core responder ----------------
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      if (rst_hit) begin
        last_res = '0;
        check("reset_addr", 64'(core_start_addr), 64'(0));
      end
      check("busy", 64'(busy), 64'(busy_arr[cyc]));
      check("all_done", 64'(all_done), 64'(ad_arr[cyc]));
      if (start_q.size() > 0 && start_q[0][41:10] == 32'(cyc)) begin
        check("core_start", 64'(core_start), 64'(1));
        check("start_addr", 64'(core_start_addr), 64'(start_q[0][9:0]));
        void'(start_q.pop_front());
      end else begin
        check("core_start", 64'(core_start), 64'(0));
      end
      if (exp_q.size() > 0 && exp_q[0][50:19] == 32'(cyc)) begin
        last_res = exp_q[0][18:0];
        check("result_valid", 64'(result_valid), 64'(1));
        check("result", 64'({result_prog, result_cycles, result_timeout}), 64'(last_res));
        void'(exp_q.pop_front());
      end else begin
        check("result_valid", 64'(result_valid), 64'(0));
        check("result_hold", 64'({result_prog, result_cycles, result_timeout}), 64'(last_res));
      end
      // core: done stays as-is through LAUNCH, then rises in RUN cycle d and stays up
      if (core_start) begin
        k     = 0;
        d_cur = (d_q.size() > 0) ? d_q.pop_front() : (1 << 30);
      end else begin
        k++;
        core_done = (k >= d_cur);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
    go      = 1'b0;
    abort   = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic drop_after(input int a);
    logic [41:0] s_tmp[$];
    logic [50:0] r_tmp[$];
    s_tmp = start_q;
    r_tmp = exp_q;
    start_q.delete();
    exp_q.delete();
    foreach (s_tmp[i]) if (s_tmp[i][41:10] <= 32'(a)) start_q.push_back(s_tmp[i]);
    foreach (r_tmp[i]) if (r_tmp[i][50:19] <= 32'(a)) exp_q.push_back(r_tmp[i]);
    for (int t = a + 1; t < MAXC; t++) begin
      busy_arr[t] = 1'b0;
      ad_arr[t]   = 1'b0;
    end
    d_q.delete();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy_arr[cyc]; i++) step();
    if (busy_arr[cyc]) check("idle_wait", 64'(busy_arr[cyc]), 64'(0));
  endtask

  task automatic launch(input logic [2:0] m, input int d0, input int d1, input int d2);
    int ds[3];
    int s, r, c, f, g;
    wait_idle();
    g  = cyc;
    ds = '{d0, d1, d2};
    s  = g + 1;
    f  = g + 1;
    for (int i = 0; i < 3; i++) begin
      if (m[i]) begin
        c = (ds[i] < TO) ? ds[i] : TO;
        r = s + c + 1;
        start_q.push_back({32'(s), 10'(addr_tab[i])});
        exp_q.push_back({32'(r), 2'(i), 16'(c), ds[i] > TO});
        d_q.push_back(ds[i]);
        f = r + 1;
        s = r + 1;
      end
    end
    for (int t = g + 1; t < MAXC; t++) begin
      busy_arr[t] = (t <= f);
      ad_arr[t]   = (t > f);
    end
    go        = 1'b1;
    prog_mask = m;
    step();
  endtask

  task automatic do_abort();
    abort = 1'b1;
    drop_after(cyc);
    step();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    go        = 1'b1;
    prog_mask = 3'($urandom_range(1, 7));
    abort     = 1'($urandom_range(0, 1));
    drop_after(cyc);
    step();
  endtask

  function automatic int pick_d();
    case ($urandom_range(0, 5))
      0:       return 1;
      1:       return $urandom_range(2, 20);
      2:       return TO - 1;
      3:       return TO;
      4:       return TO + 1;
      default: return 500;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int g;
    reset_n   = 1'b0;
    go        = 1'b0;
    prog_mask = 3'b000;
    abort     = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    step();

    launch(3'b111, 20, 35, 50);            // three programs, ordered addresses
    launch(3'b010, 1, 5, 1);               // done still high from previous run
    launch(3'b101, 500, 1, 500);           // both time out
    launch(3'b001, TO, 1, 1);              // done in last allowed cycle
    launch(3'b100, 1, 1, TO - 1);
    launch(3'b010, 1, TO + 1, 1);

    launch(3'b011, 10, 100, 1);            // abort inside program 1 RUN
    g = cyc - 1;
    while (cyc < g + 18) step();
    do_abort();
    launch(3'b000, 1, 1, 1);               // empty mask: straight to FINISH

    launch(3'b111, 30, 30, 30);            // reset mid-run, with go held
    g = cyc - 1;
    while (cyc < g + 10) step();
    do_reset();

    launch(3'b001, 15, 1, 1);              // go during busy is ignored
    repeat (5) begin
      go        = 1'b1;
      prog_mask = 3'b111;
      step();
    end

    for (int n = 0; n < 30 && cyc < MAXC - 800; n++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) begin
        abort = ($urandom_range(0, 3) == 0);
        step();
      end
      launch(3'($urandom_range(0, 7)), pick_d(), pick_d(), pick_d());
      while (busy_arr[cyc] && cyc < MAXC - 800) begin
        int r;
        r = $urandom_range(0, 199);
        if (r < 2) begin
          do_reset();
        end else if (r < 5) begin
          do_abort();
        end else begin
          if (r < 35) begin
            go        = 1'b1;
            prog_mask = 3'($urandom_range(0, 7));
          end
          step();
        end
      end
    end

    wait_idle();
    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
